// File: rtl/kyber_pkg.sv
// kyber_pkg: shared constants, operation encoding and modular add/sub helpers
// for the Kyber butterfly datapath. All arithmetic is mod Q = 3329.
package kyber_pkg;

   localparam int unsigned W         = 12;          // coefficient width
   localparam int unsigned Q         = 3329;        // Kyber modulus
   localparam int unsigned BARRETT_M = 5039;        // floor(2^24 / Q)
   localparam int unsigned BARRETT_K = 24;          // Barrett shift
   localparam int unsigned LATENCY   = 4;           // sample edge to output edge
   localparam int unsigned PROD_W    = 2 * W;       // full product width
   localparam int unsigned QM_W      = PROD_W + 13; // product times BARRETT_M

   typedef enum logic [1:0] {
      MODE_NTT    = 2'd0,
      MODE_INVNTT = 2'd1,
      MODE_MULT   = 2'd2,
      MODE_ADDSUB = 2'd3
   } mode_t;

   // One conditional subtraction brings any 12-bit value into [0, Q-1].
   function automatic logic [W-1:0] pre_reduce(input logic [W-1:0] x);
      return (x >= W'(Q)) ? (x - W'(Q)) : x;
   endfunction

   // (a + b) mod Q for canonical a, b: 13-bit sum, conditional -Q.
   function automatic logic [W-1:0] add_mod(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= (W+1)'(Q))
         s = s - (W+1)'(Q);
      return s[W-1:0];
   endfunction

   // (a - b) mod Q for canonical a, b: the top bit of the 13-bit difference
   // flags a negative result, which is folded back by adding Q.
   function automatic logic [W-1:0] sub_mod(input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic [W:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[W])
         d = d + (W+1)'(Q);
      return d[W-1:0];
   endfunction

endpackage

// File: rtl/mod_mult.sv
// mod_mult: two-stage pipelined (x * y) mod Q for canonical 12-bit operands.
//   Stage A: full 24-bit product register.
//   Stage B: Barrett reduction plus up to two corrections into z.
// Ports: clk, rst (sync, active high), x/y operands, z = x*y mod Q.
module mod_mult
   import kyber_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic [W-1:0] z
);

   logic [PROD_W-1:0] prod;
   logic [QM_W-1:0]   quot;
   logic [W+1:0]      rem;
   logic [W+1:0]      rem_1;
   logic [W-1:0]      z_next;

   // Stage A: full product
   always_ff @(posedge clk) begin
      if (rst)
         prod <= '0;
      else
         prod <= PROD_W'(x) * PROD_W'(y);
   end

   // Barrett estimate undershoots the true quotient by at most 2, so the
   // remainder lies in [0, 3Q) and fits in 14 bits.
   always_comb begin
      quot   = (QM_W'(prod) * QM_W'(BARRETT_M)) >> BARRETT_K;
      rem    = (W+2)'(QM_W'(prod) - quot * QM_W'(Q));
      rem_1  = (rem >= (W+2)'(Q)) ? (rem - (W+2)'(Q)) : rem;
      z_next = (rem_1 >= (W+2)'(Q)) ? W'(rem_1 - (W+2)'(Q)) : W'(rem_1);
   end

   // Stage B: reduced result
   always_ff @(posedge clk) begin
      if (rst)
         z <= '0;
      else
         z <= z_next;
   end

endmodule

// File: rtl/butterfly_core.sv
// butterfly_core: fixed-latency Kyber butterfly / modular arithmetic unit.
// An operation sampled at edge k appears on out_1/out_2 after edge k+4.
//   mode 0 NTT    : out_1 = a + c*b,  out_2 = a - c*b
//   mode 1 INVNTT : out_1 = a + b,    out_2 = c*(b - a)
//   mode 2 MULT   : out_1 = c*a,      out_2 = c*b
//   mode 3 ADDSUB : out_1 = a + b,    out_2 = a - b
// Ports: clk, rst (sync, active high), mode, in_1 (a), in_2 (b), coef (c),
//        out_1/out_2 registered canonical results.
module butterfly_core
   import kyber_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   mode,
   input  logic [W-1:0] in_1,
   input  logic [W-1:0] in_2,
   input  logic [W-1:0] coef,
   output logic [W-1:0] out_1,
   output logic [W-1:0] out_2
);

   // capture stage
   mode_t        s0_mode;
   logic [W-1:0] s0_a, s0_b, s0_c;

   // pre-reduce stage
   logic [W-1:0] a_red, b_red, c_red, lane1_x;
   mode_t        s1_mode;
   logic [W-1:0] s1_a, s1_b, s1_c, s1_x1;

   // delay-matched bypass for the two multiplier stages
   mode_t        s2_mode, s3_mode;
   logic [W-1:0] s2_a, s2_b, s3_a, s3_b;

   // lane results, aligned with stage 3
   logic [W-1:0] t1, t2;

   logic [W-1:0] res_1, res_2;

   // Raw operand capture
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_mode <= MODE_NTT;
         s0_a    <= '0;
         s0_b    <= '0;
         s0_c    <= '0;
      end else begin
         s0_mode <= mode_t'(mode);
         s0_a    <= in_1;
         s0_b    <= in_2;
         s0_c    <= coef;
      end
   end

   // Pre-reduce and choose the lane 1 multiplicand for this mode
   always_comb begin
      a_red   = pre_reduce(s0_a);
      b_red   = pre_reduce(s0_b);
      c_red   = pre_reduce(s0_c);
      lane1_x = a_red;
      case (s0_mode)
         MODE_NTT:    lane1_x = b_red;
         MODE_INVNTT: lane1_x = sub_mod(b_red, a_red);
         default:     lane1_x = a_red;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_mode <= MODE_NTT;
         s1_a    <= '0;
         s1_b    <= '0;
         s1_c    <= '0;
         s1_x1   <= '0;
      end else begin
         s1_mode <= s0_mode;
         s1_a    <= a_red;
         s1_b    <= b_red;
         s1_c    <= c_red;
         s1_x1   <= lane1_x;
      end
   end

   // Lane 1 serves every multiplying mode; lane 2 only matters for MULT
   mod_mult u_lane_1 (
      .clk (clk),
      .rst (rst),
      .x   (s1_x1),
      .y   (s1_c),
      .z   (t1)
   );

   mod_mult u_lane_2 (
      .clk (clk),
      .rst (rst),
      .x   (s1_b),
      .y   (s1_c),
      .z   (t2)
   );

   // Carry mode and plain operands alongside the multiplier pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         s2_mode <= MODE_NTT;
         s2_a    <= '0;
         s2_b    <= '0;
         s3_mode <= MODE_NTT;
         s3_a    <= '0;
         s3_b    <= '0;
      end else begin
         s2_mode <= s1_mode;
         s2_a    <= s1_a;
         s2_b    <= s1_b;
         s3_mode <= s2_mode;
         s3_a    <= s2_a;
         s3_b    <= s2_b;
      end
   end

   // Final combine per mode
   always_comb begin
      res_1 = add_mod(s3_a, s3_b);
      res_2 = sub_mod(s3_a, s3_b);
      case (s3_mode)
         MODE_NTT: begin
            res_1 = add_mod(s3_a, t1);
            res_2 = sub_mod(s3_a, t1);
         end
         MODE_INVNTT: begin
            res_1 = add_mod(s3_a, s3_b);
            res_2 = t1;
         end
         MODE_MULT: begin
            res_1 = t1;
            res_2 = t2;
         end
         default: begin
            res_1 = add_mod(s3_a, s3_b);
            res_2 = sub_mod(s3_a, s3_b);
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_1 <= '0;
         out_2 <= '0;
      end else begin
         out_1 <= res_1;
         out_2 <= res_2;
      end
   end

endmodule

// File: tb/tb_butterfly_core.sv
// tb_butterfly_core: self-checking bench for butterfly_core. Inputs are driven
// on the falling edge; outputs are sampled on the falling edge, so a result
// driven at falling edge n is observed at falling edge n + LATENCY + 1.
module tb_butterfly_core;
   import kyber_pkg::*;

   localparam int QI      = 3329;
   localparam int CHK_DLY = LATENCY + 1;
   localparam int N_RAND  = 10000;

   logic         clk = 1'b0;
   logic         rst;
   logic [1:0]   mode;
   logic [W-1:0] in_1, in_2, coef;
   logic [W-1:0] out_1, out_2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   butterfly_core dut (
      .clk   (clk),
      .rst   (rst),
      .mode  (mode),
      .in_1  (in_1),
      .in_2  (in_2),
      .coef  (coef),
      .out_1 (out_1),
      .out_2 (out_2)
   );

   // Reference: plain integer mod-Q arithmetic on the specified formulas
   function automatic void golden(input int m, input int a, input int b,
                                  input int c, output int o1, output int o2);
      int ar, br, cr, t;
      ar = a % QI;
      br = b % QI;
      cr = c % QI;
      case (m)
         0: begin
            t  = (cr * br) % QI;
            o1 = (ar + t) % QI;
            o2 = (ar - t + QI) % QI;
         end
         1: begin
            o1 = (ar + br) % QI;
            o2 = (cr * ((br - ar + QI) % QI)) % QI;
         end
         2: begin
            o1 = (cr * ar) % QI;
            o2 = (cr * br) % QI;
         end
         default: begin
            o1 = (ar + br) % QI;
            o2 = (ar - br + QI) % QI;
         end
      endcase
   endfunction

   task automatic drive(input int m, input int a, input int b, input int c);
      mode = 2'(m);
      in_1 = W'(a);
      in_2 = W'(b);
      coef = W'(c);
   endtask

   task automatic drive_random();
      drive(int'($urandom_range(0, 3)), int'($urandom_range(0, 4095)),
            int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
   endtask

   // Outputs held at zero while reset is asserted with random inputs
   task automatic test_reset();
      rst = 1'b1;
      drive_random();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (out_1 !== '0 || out_2 !== '0) begin
            errors++;
            $display("FAIL reset[%0d]: out_1=%0d out_2=%0d expected 0 0", i, out_1, out_2);
         end
         drive_random();
      end
   endtask

   // Back-to-back NTT from reset release; outputs zero until first result
   task automatic test_ntt();
      int ta[3] = '{123, 0, 50};
      int tb[3] = '{345, 345, 3328};
      int tc[3] = '{50, 50, 2};
      int e1[3] = '{728, 605, 48};
      int e2[3] = '{2847, 2724, 52};
      int k;
      for (int j = 0; j < 3 + CHK_DLY; j++) begin
         @(negedge clk);
         checks++;
         if (j < CHK_DLY) begin
            if (out_1 !== '0 || out_2 !== '0) begin
               errors++;
               $display("FAIL ntt_idle[%0d]: out_1=%0d out_2=%0d expected 0 0", j, out_1, out_2);
            end
         end else begin
            k = j - CHK_DLY;
            if (out_1 !== W'(e1[k]) || out_2 !== W'(e2[k])) begin
               errors++;
               $display("FAIL ntt[%0d]: out_1=%0d out_2=%0d expected %0d %0d",
                        k, out_1, out_2, e1[k], e2[k]);
            end
         end
         rst = 1'b0;
         if (j < 3) drive(0, ta[j], tb[j], tc[j]);
         else       drive(3, 0, 0, 0);
      end
   endtask

   task automatic test_invntt();
      int ta[2] = '{2847, 52};
      int tb[2] = '{728, 48};
      int tc[2] = '{3279, 3327};
      int e1[2] = '{246, 100};
      int e2[2] = '{2751, 8};
      int k;
      for (int j = 0; j < 2 + CHK_DLY; j++) begin
         @(negedge clk);
         if (j >= CHK_DLY) begin
            k = j - CHK_DLY;
            checks++;
            if (out_1 !== W'(e1[k]) || out_2 !== W'(e2[k])) begin
               errors++;
               $display("FAIL invntt[%0d]: out_1=%0d out_2=%0d expected %0d %0d",
                        k, out_1, out_2, e1[k], e2[k]);
            end
         end
         if (j < 2) drive(1, ta[j], tb[j], tc[j]);
         else       drive(3, 0, 0, 0);
      end
   endtask

   task automatic test_mult_addsub();
      int tm[2] = '{2, 3};
      int e1[2] = '{797, 246};
      int e2[2] = '{219, 2119};
      int k;
      for (int j = 0; j < 2 + CHK_DLY; j++) begin
         @(negedge clk);
         if (j >= CHK_DLY) begin
            k = j - CHK_DLY;
            checks++;
            if (out_1 !== W'(e1[k]) || out_2 !== W'(e2[k])) begin
               errors++;
               $display("FAIL mult_addsub[%0d]: out_1=%0d out_2=%0d expected %0d %0d",
                        k, out_1, out_2, e1[k], e2[k]);
            end
         end
         if (j < 2) drive(tm[j], 2847, 728, 3279);
         else       drive(3, 0, 0, 0);
      end
   endtask

   // Mode changes every cycle with zero, Q-1 and out-of-range operands
   task automatic test_boundaries();
      int tm[5] = '{3, 0, 3, 2, 1};
      int ta[5] = '{0, 3328, 4095, 4095, 4095};
      int tb[5] = '{0, 3328, 0, 4095, 3329};
      int tc[5] = '{0, 3328, 0, 4095, 3329};
      int e1[5] = '{0, 0, 766, 852, 766};
      int e2[5] = '{0, 3327, 766, 852, 0};
      int k;
      for (int j = 0; j < 5 + CHK_DLY; j++) begin
         @(negedge clk);
         if (j >= CHK_DLY) begin
            k = j - CHK_DLY;
            checks++;
            if (out_1 !== W'(e1[k]) || out_2 !== W'(e2[k])) begin
               errors++;
               $display("FAIL boundary[%0d]: out_1=%0d out_2=%0d expected %0d %0d",
                        k, out_1, out_2, e1[k], e2[k]);
            end
         end
         if (j < 5) drive(tm[j], ta[j], tb[j], tc[j]);
         else       drive(3, 0, 0, 0);
      end
   endtask

   // Random modes and operands every cycle against the reference model
   task automatic test_random();
      int q1[$];
      int q2[$];
      int m, a, b, c, o1, o2, x1, x2;
      for (int j = 0; j < N_RAND + CHK_DLY; j++) begin
         @(negedge clk);
         if (j >= CHK_DLY) begin
            x1 = q1.pop_front();
            x2 = q2.pop_front();
            checks++;
            if (out_1 !== W'(x1) || out_2 !== W'(x2)) begin
               errors++;
               $display("FAIL random[%0d]: out_1=%0d out_2=%0d expected %0d %0d",
                        j - CHK_DLY, out_1, out_2, x1, x2);
            end
         end
         if (j < N_RAND) begin
            m = int'($urandom_range(0, 3));
            a = int'($urandom_range(0, 4095));
            b = int'($urandom_range(0, 4095));
            c = int'($urandom_range(0, 4095));
            golden(m, a, b, c, o1, o2);
            q1.push_back(o1);
            q2.push_back(o2);
            drive(m, a, b, c);
         end else begin
            drive(3, 0, 0, 0);
         end
      end
   endtask

   // Reset with three ops in flight: none of them may ever surface
   task automatic test_reset_inflight();
      drive(3, 1, 2, 0);
      @(negedge clk);
      drive(0, 100, 200, 300);
      @(negedge clk);
      drive(2, 1000, 2000, 3000);
      @(negedge clk);
      rst = 1'b1;
      drive(0, 7, 8, 9);
      @(negedge clk);
      checks++;
      if (out_1 !== '0 || out_2 !== '0) begin
         errors++;
         $display("FAIL inflight_reset: out_1=%0d out_2=%0d expected 0 0", out_1, out_2);
      end
      rst = 1'b0;
      drive(3, 0, 0, 0);
      for (int j = 0; j < 6; j++) begin
         @(negedge clk);
         checks++;
         if (out_1 !== '0 || out_2 !== '0) begin
            errors++;
            $display("FAIL inflight_flush[%0d]: out_1=%0d out_2=%0d expected 0 0",
                     j, out_1, out_2);
         end
      end
   endtask

   initial begin
      test_reset();
      test_ntt();
      test_invntt();
      test_mult_addsub();
      test_boundaries();
      test_random();
      test_reset_inflight();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/butterfly_core.md
Name: butterfly_core

Overview:
- Pipelined modular arithmetic unit for the CRYSTALS-Kyber polynomial engine. All arithmetic is mod q = 3329.
- Performs one Cooley-Tukey NTT butterfly, one Gentleman-Sande inverse-NTT butterfly, a dual scalar multiply, or a plain add/sub per cycle.
- Sits between the coefficient memory and the NTT controller. It has a fixed latency and no handshake.

Parameters:
- Q, 3329, Kyber modulus (fixed; the RTL is not required to support other values).
- W, 12, coefficient width.
- LATENCY, 4, input-to-output pipeline depth in cycles (fixed).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mode  in  2  operation select: 0 NTT, 1 INVNTT, 2 MULT, 3 ADDSUB.
- in_1  in  12  operand a (lower butterfly leg).
- in_2  in  12  operand b (upper butterfly leg).
- coef  in  12  twiddle/scale factor c.
- out_1  out  12  result 1, registered, range [0, Q-1].
- out_2  out  12  result 2, registered, range [0, Q-1].

Behaviour:
- Reset: while rst=1 at a rising edge, every pipeline stage and out_1/out_2 are cleared to 0. Reset mid-operation discards all in-flight results.
- Sampling and latency:
  - mode, in_1, in_2 and coef are sampled on every rising edge with rst=0. The block accepts one operation per cycle with no stall or valid signal.
  - A result sampled at edge k appears on out_1/out_2 after edge k+4.
  - mode travels with its data, so mode may change every cycle without corrupting in-flight ops.
  - After reset release, outputs stay 0 until the first sampled op emerges.
- Input range: in_1, in_2 and coef values >= Q (3329..4095) are pre-reduced by one conditional subtraction of Q in stage 1. All math uses canonical values in [0, Q-1].
- Operations (all results canonical mod Q):
  - mode 0 NTT: t = c*b; out_1 = a + t; out_2 = a - t.
  - mode 1 INVNTT: out_1 = a + b; out_2 = c*(b - a). No division by 2.
  - mode 2 MULT: out_1 = c*a; out_2 = c*b.
  - mode 3 ADDSUB: out_1 = a + b; out_2 = a - b.
- Arithmetic:
  - Additions use a 13-bit sum with a conditional -Q.
  - Subtractions add Q when negative.
  - Products are full 24-bit values, reduced by Barrett reduction (k=24, m=floor(2^24/Q)=5039) followed by conditional subtraction of Q until the result is < Q (at most 2). Results must be exact for every product < Q^2.
- Pipeline:
  - S1: register inputs, pre-reduce, compute the INVNTT difference.
  - S2: 12x12 multiply.
  - S3: Barrett quotient and remainder.
  - S4: final add/sub/correction into output registers.
  - MULT uses two multiplier/reducer lanes. The other modes use lane 1; ADDSUB bypasses it with delay-matched registers.

Decomposition:
- Package kyber_pkg holds:
  - Q=3329, W=12, BARRETT_M=5039, BARRETT_K=24;
  - the mode enum (MODE_NTT=0, MODE_INVNTT=1, MODE_MULT=2, MODE_ADDSUB=3);
  - add_mod/sub_mod functions.
- One sub-module, mod_mult: a 2-stage pipelined 12x12 multiply plus Barrett reduce, instantiated twice.

Test Plan:
- Reset: hold rst=1 for 5 cycles with random inputs -> out_1=out_2=0 throughout; after release outputs are 0 until the first op emerges 4 cycles later.
- NTT, back-to-back from reset release:
  - (a,b,c) = (123,345,50) -> (728,2847)
  - (0,345,50) -> (605,2724)
  - (50,3328,2) -> (48,52)
  - Each result lands on consecutive cycles, 4 cycles after its input.
- INVNTT: (a=2847, b=728, c=3279) -> (246, 2751); (a=52, b=48, c=3327) -> (100, 8).
- MULT: (a=2847, b=728, c=3279) -> (797, 219); ADDSUB with the same inputs -> (246, 2119).
- Mode switching every cycle plus boundaries:
  - ADDSUB (0,0) -> (0,0)
  - NTT (3328,3328,3328) -> (0,3327)
  - input 4095 treated as 766
  - Compare every lane against a golden mod-Q model for 10k random ops.
- Reset asserted while 3 ops are in flight -> none of them ever appear; outputs are 0 on the edge after reset.
